// File: rtl/max_seq_pkg.sv
// Shared types and defaults for the sequential max-reduction controller.
package max_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } state_e;

   localparam int unsigned DefWidth  = 8;
   localparam int unsigned DefNumOps = 8;

   // Fallback for toolflows without $clog2.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/max_cmp_stage.sv
// Combinational max comparator/mux, kept separate so an approximate netlist can replace it.
module max_cmp_stage
   import max_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             first,
   output logic             sel,
   output logic [WIDTH-1:0] max_val
);

   // Strict compare: ties keep a, i.e. the earlier operand.
   assign sel     = first || (b > a);
   assign max_val = sel ? b : a;

endmodule

// File: rtl/max_seq_ctrl.sv
// Time-shared running-max controller over NUM_OPS operands with valid/ready in and out.
// Define MAX_SEQ_ARGMAX_EN to track and report the argmax index on out_idx.
module max_seq_ctrl
   import max_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned NUM_OPS = DefNumOps,
   parameter int unsigned IDX_W   = $clog2(NUM_OPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDX_W-1:0] out_idx,
   output logic             busy
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_OPS - 1);

   state_e           state_q;
   logic [IDX_W-1:0] counter_q;
   logic [WIDTH-1:0] run_max_q;
   logic             xfer;
   logic             first_op;
   logic             last_op;
   logic             cmp_sel;
   logic [WIDTH-1:0] cmp_max;

   // in_ready is only high in StAccum, so xfer implies the accumulate state.
   assign xfer     = in_valid && in_ready;
   assign first_op = (counter_q == '0);
   assign last_op  = (counter_q == LastIdx);

   max_cmp_stage #(
      .WIDTH(WIDTH)
   ) u_cmp (
      .a      (run_max_q),
      .b      (in_data),
      .first  (first_op),
      .sel    (cmp_sel),
      .max_val(cmp_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         counter_q <= '0;
         run_max_q <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_max   <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q   <= StAccum;
                  counter_q <= '0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            StAccum: begin
               if (xfer) begin
                  if (cmp_sel) run_max_q <= in_data;
                  if (last_op) begin
                     out_max   <= cmp_max;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     state_q   <= StDone;
                  end else begin
                     counter_q <= counter_q + 1'b1;
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef MAX_SEQ_ARGMAX_EN
   logic [IDX_W-1:0] run_idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_idx_q <= '0;
         out_idx   <= '0;
      end else if (xfer) begin
         if (cmp_sel) run_idx_q <= counter_q;
         if (last_op) out_idx <= cmp_sel ? counter_q : run_idx_q;
      end
   end
`else
   assign out_idx = '0;
`endif

endmodule

// File: tb/tb_max_seq_ctrl.sv
// Scoreboard bench for max_seq_ctrl: directed reductions, backpressure, mid-op reset.
module tb_max_seq_ctrl;

   typedef logic [7:0] ops_t[8];
   typedef struct packed {
      logic [7:0] mx;
      logic [2:0] idx;
   } res_t;

`ifdef MAX_SEQ_ARGMAX_EN
   localparam bit ArgMax = 1'b1;
`else
   localparam bit ArgMax = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_max;
   logic [2:0] out_idx;
   logic       busy;

   int   tests = 0;
   int   fails = 0;
   res_t exp_q[$];
   res_t cur;
   bit   have_cur = 1'b0;

   max_seq_ctrl #(
      .WIDTH  (8),
      .NUM_OPS(8),
      .IDX_W  (3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_max  (out_max),
      .out_idx  (out_idx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops on the first cycle a result is presented, then checks it stays stable.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!have_cur) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out_valid: got max %0d idx %0d, expected none (t=%0t)",
                        out_max, out_idx, $time);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               check("out_max", 32'(out_max), 32'(cur.mx));
               check("out_idx", 32'(out_idx), 32'(cur.idx));
            end
         end else begin
            check("hold_max", 32'(out_max), 32'(cur.mx));
            check("hold_idx", 32'(out_idx), 32'(cur.idx));
         end
         if (out_ready) have_cur = 1'b0;
      end
   end

   // Feeds 8 operands; optional idle gaps, result backpressure and a stray start in ACCUM.
   task automatic run_red(input ops_t ops, input logic [7:0] exp_max, input logic [2:0] exp_idx,
                          input bit toggle, input int hold, input bit mid_start);
      res_t e;
      bit   got;
      int   n;
      e.mx  = exp_max;
      e.idx = ArgMax ? exp_idx : 3'd0;
      exp_q.push_back(e);
      out_ready = (hold == 0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_accum", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (toggle) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = ops[i];
         if (mid_start && i == 4) start = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
         end while (!got && n < 20);
         if (!got) check("xfer_timeout", 32'(got), 32'd1);
      end
      // Data offered in DONE must be ignored.
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check("latency_valid", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
         end
         @(posedge clk); #1 out_ready = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      check("valid_drop", 32'(out_valid), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset / idle with in_valid asserted and no start.
      in_valid = 1'b1;
      in_data  = 8'd77;
      #23 rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle_in_ready", 32'(in_ready), 32'd0);
         check("idle_out_valid", 32'(out_valid), 32'd0);
         check("idle_out_max", 32'(out_max), 32'd0);
         check("idle_out_idx", 32'(out_idx), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1 in_valid = 1'b0;

      // Basic reduction, tie at 200 keeps index 3; accepted on the first valid cycle.
      run_red('{8'd3, 8'd17, 8'd9, 8'd200, 8'd5, 8'd200, 8'd1, 8'd0}, 8'd200, 3'd3, 1'b0, 0, 1'b0);
      // Backpressure on both channels.
      run_red('{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 8'd80, 3'd7, 1'b1, 5, 1'b0);
      run_red('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd0, 3'd0, 1'b0, 0, 1'b0);
      run_red('{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
              8'd255, 3'd0, 1'b0, 2, 1'b0);
      // Stray start during ACCUM must not restart the count.
      run_red('{8'd3, 8'd17, 8'd9, 8'd200, 8'd5, 8'd200, 8'd1, 8'd0}, 8'd200, 3'd3, 1'b0, 0, 1'b1);

      // Mid-op asynchronous reset after 4 operands including 250.
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = (i == 1) ? 8'd250 : 8'(i + 4);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_valid", 32'(out_valid), 32'd0);
      end
      run_red('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 8'd8, 3'd7, 1'b0, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
